// File: rtl/fast_accel_mac_pkg.sv
// Shared types, limits and saturation helpers for the fast_accel multiply/MAC pipeline.
package fast_accel_mac_pkg;

    localparam int NUM_STAGE_MIN = 3;
    localparam int NUM_STAGE_MAX = 8;
    // Widest intermediate the saturation helpers accept; callers size-extend into it.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic valid;
        logic acc_en;
        logic acc_clr;
    } sideband_t;

    typedef struct packed {
        logic [SAT_W-1:0] value;
        logic             sat;
    } sat_res_t;

    // Clip a sign-extended value to the two's complement range of out_w bits.
    function automatic sat_res_t sat_signed(input logic [SAT_W-1:0] r, input int unsigned out_w);
        logic signed [SAT_W-1:0] v;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t res;
        v = $signed(r);
        hi = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        lo = ~hi;
        res.value = r;
        res.sat = 1'b0;
        if (v > hi) begin
            res.value = hi;
            res.sat = 1'b1;
        end else if (v < lo) begin
            res.value = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

    // Clip a zero-extended value to 0 .. 2^out_w-1.
    function automatic sat_res_t sat_unsigned(input logic [SAT_W-1:0] r, input int unsigned out_w);
        logic [SAT_W-1:0] hi;
        sat_res_t res;
        hi = (SAT_W'(1) << out_w) - SAT_W'(1);
        res.value = r;
        res.sat = 1'b0;
        if (r > hi) begin
            res.value = hi;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fast_accel_mac_dly.sv
// Clock-enabled delay line with synchronous reset; DEPTH=0 degenerates to a wire.
module fast_accel_mac_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, ce};
            assign q = d;
        end else begin : g_line
            logic [WIDTH-1:0] line [DEPTH];

            // NOTE: every entry is reset, not just a valid column, because the valid
            // bit travels packed inside each word and must never come out stale.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) line[i] <= '0;
                end else if (ce) begin
                    line[0] <= d;
                    for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
                end
            end

            assign q = line[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fast_accel_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with rounding shift and saturating output.
module fast_accel_mac_pipe
    import fast_accel_mac_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0,
    parameter int NUM_STAGE = 4,
    parameter int ACC_WIDTH = 48,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam int PROD_W     = A_WIDTH + B_WIDTH;
    localparam int R_W        = ACC_WIDTH + 1;
    localparam int SB_W       = $bits(sideband_t);
    localparam int DLY_W      = PROD_W + SB_W;
    localparam logic [R_W-1:0] ROUND = (R_W'(1) << SHIFT) >> 1;

    generate
        if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_chk_stage
            $error("fast_accel_mac_pipe: NUM_STAGE out of range");
        end
        if (ACC_WIDTH < PROD_W || ACC_WIDTH >= SAT_W) begin : g_chk_acc
            $error("fast_accel_mac_pipe: ACC_WIDTH out of range");
        end
        if (SHIFT < 0 || SHIFT >= ACC_WIDTH) begin : g_chk_shift
            $error("fast_accel_mac_pipe: SHIFT out of range");
        end
    endgenerate

    logic [A_WIDTH-1:0] a_s1;
    logic [B_WIDTH-1:0] b_s1;
    sideband_t          sb_s1;
    logic [PROD_W-1:0]  prod_s2;
    sideband_t          sb_s2;
    logic [PROD_W-1:0]  prod_d;
    sideband_t          sb_d;
    logic [DLY_W-1:0]   dly_q;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [R_W-1:0]       r_sum;
    logic [R_W-1:0]       r_val;
    logic [OUT_WIDTH-1:0] dout_next;
    logic                 sat_next;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1  <= '0;
            b_s1  <= '0;
            sb_s1 <= '0;
        end else if (ce) begin
            a_s1  <= din0;
            b_s1  <= din1;
            sb_s1 <= '{valid: in_valid, acc_en: acc_en, acc_clr: acc_clr};
        end
    end

    // Operands are widened to the product width so the multiply is exact for every signedness mix.
    always_comb begin
        if (A_SIGNED != 0) a_ext = PROD_W'($signed(a_s1));
        else               a_ext = PROD_W'(a_s1);
        if (B_SIGNED != 0) b_ext = PROD_W'($signed(b_s1));
        else               b_ext = PROD_W'(b_s1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_s2 <= '0;
            sb_s2   <= '0;
        end else if (ce) begin
            prod_s2 <= a_ext * b_ext;
            sb_s2   <= sb_s1;
        end
    end

    fast_accel_mac_dly #(
        .DEPTH (NUM_STAGE - 3),
        .WIDTH (DLY_W)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .d     ({prod_s2, sb_s2}),
        .q     (dly_q)
    );

    assign prod_d = dly_q[DLY_W-1:SB_W];
    assign sb_d   = dly_q[SB_W-1:0];

    // Accumulate, then round half-up in one extra bit so the +2^(SHIFT-1) cannot overflow.
    always_comb begin
        if (RES_SIGNED) p_ext = ACC_WIDTH'($signed(prod_d));
        else            p_ext = ACC_WIDTH'(prod_d);
        if (sb_d.acc_en && !sb_d.acc_clr) acc_next = acc + p_ext;
        else                              acc_next = p_ext;
        if (RES_SIGNED) r_sum = {acc_next[ACC_WIDTH-1], acc_next} + ROUND;
        else            r_sum = {1'b0, acc_next} + ROUND;
        if (RES_SIGNED) r_val = $signed(r_sum) >>> SHIFT;
        else            r_val = r_sum >> SHIFT;
    end

    generate
        if (OUT_WIDTH >= R_W) begin : g_extend
            always_comb begin
                if (RES_SIGNED) dout_next = OUT_WIDTH'($signed(r_val));
                else            dout_next = OUT_WIDTH'(r_val);
                sat_next = 1'b0;
            end
        end else begin : g_saturate
            sat_res_t         sat_res;
            logic [SAT_W-1:0] r_wide;
            logic             unused_sat_hi;
            always_comb begin
                if (RES_SIGNED) begin
                    r_wide  = SAT_W'($signed(r_val));
                    sat_res = sat_signed(r_wide, OUT_WIDTH);
                end else begin
                    r_wide  = SAT_W'(r_val);
                    sat_res = sat_unsigned(r_wide, OUT_WIDTH);
                end
                dout_next = sat_res.value[OUT_WIDTH-1:0];
                sat_next  = sat_res.sat;
            end
            assign unused_sat_hi = ^sat_res.value[SAT_W-1:OUT_WIDTH];
        end
    endgenerate

    // Bubbles only drop out_valid; dout, sat and the accumulator keep the last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            dout      <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= sb_d.valid;
            if (sb_d.valid) begin
                dout <= dout_next;
                sat  <= sat_next;
                if (sb_d.acc_en) acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_fast_accel_mac_pipe.sv
// Directed bench for fast_accel_mac_pipe across several parameter sets sharing one stimulus bus.
module tb_fast_accel_mac_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        acc_en;
    logic        acc_clr;

    logic        def_valid, def_sat;
    logic [31:0] def_dout;
    logic        n3_valid, n3_sat;
    logic [31:0] n3_dout;
    logic        sgn_valid, sgn_sat;
    logic [15:0] sgn_dout;
    logic        shf_valid, shf_sat;
    logic [31:0] shf_dout;
    logic        u8_valid, u8_sat;
    logic [7:0]  u8_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fast_accel_mac_pipe u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(def_valid), .dout(def_dout), .sat(def_sat)
    );

    fast_accel_mac_pipe #(.NUM_STAGE(3)) u_n3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(n3_valid), .dout(n3_dout), .sat(n3_sat)
    );

    fast_accel_mac_pipe #(.A_SIGNED(1), .B_SIGNED(1), .OUT_WIDTH(16)) u_sgn (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(sgn_valid), .dout(sgn_dout), .sat(sgn_sat)
    );

    fast_accel_mac_pipe #(.SHIFT(2)) u_shf (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(shf_valid), .dout(shf_dout), .sat(shf_sat)
    );

    fast_accel_mac_pipe #(.OUT_WIDTH(8)) u_u8 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(u8_valid), .dout(u8_dout), .sat(u8_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic en, input logic clr);
        in_valid = v;
        din0     = a;
        din1     = b;
        acc_en   = en;
        acc_clr  = clr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        n_vec++;
        if (def_valid !== 1'b0 || def_dout !== 32'd0 || def_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_def: got v=%b d=%h s=%b, expected v=0 d=0 s=0", def_valid, def_dout, def_sat);
        end
        n_vec++;
        if (sgn_valid !== 1'b0 || sgn_dout !== 16'd0 || sgn_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sgn: got v=%b d=%h s=%b, expected v=0 d=0 s=0", sgn_valid, sgn_dout, sgn_sat);
        end
        n_vec++;
        if (n3_valid !== 1'b0 || shf_valid !== 1'b0 || u8_valid !== 1'b0 || u8_dout !== 8'd0) begin
            n_err++;
            $display("FAIL reset_misc: got n3v=%b shfv=%b u8v=%b u8d=%h, expected all 0",
                     n3_valid, shf_valid, u8_valid, u8_dout);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
            else        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (t < 3) begin
                n_vec++;
                if (def_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_early_t%0d: got valid=%b, expected 0", t, def_valid);
                end
            end
            if (t == 2) begin
                n_vec++;
                if (n3_valid !== 1'b1 || n3_dout !== 32'hFFFE0001) begin
                    n_err++;
                    $display("FAIL latency_n3: got v=%b d=%h, expected v=1 d=fffe0001", n3_valid, n3_dout);
                end
            end
            if (t == 3) begin
                n_vec++;
                if (def_valid !== 1'b1 || def_dout !== 32'hFFFE0001 || def_sat !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_def: got v=%b d=%h s=%b, expected v=1 d=fffe0001 s=0",
                             def_valid, def_dout, def_sat);
                end
                n_vec++;
                if (n3_valid !== 1'b0 || n3_dout !== 32'hFFFE0001) begin
                    n_err++;
                    $display("FAIL latency_n3_hold: got v=%b d=%h, expected v=0 d=fffe0001", n3_valid, n3_dout);
                end
            end
            if (t == 4) begin
                n_vec++;
                if (def_valid !== 1'b0 || def_dout !== 32'hFFFE0001) begin
                    n_err++;
                    $display("FAIL latency_hold: got v=%b d=%h, expected v=0 d=fffe0001", def_valid, def_dout);
                end
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] ed [3];
        logic        es [3];
        av = '{16'hFFFD, 16'h8000, 16'h8000};
        bv = '{16'd5,    16'h8000, 16'h0001};
        ed = '{16'hFFF1, 16'h7FFF, 16'h8000};
        es = '{1'b0,     1'b1,     1'b0};
        for (int t = 0; t < 6; t++) begin
            if (t < 3) drive(av[t], bv[t], 1'b1, 1'b0, 1'b0);
            else       drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (t >= 3) begin
                n_vec++;
                if (sgn_valid !== 1'b1 || sgn_dout !== ed[t-3] || sgn_sat !== es[t-3]) begin
                    n_err++;
                    $display("FAIL signed_%0d: got v=%b d=%h s=%b, expected v=1 d=%h s=%b",
                             t - 3, sgn_valid, sgn_dout, sgn_sat, ed[t-3], es[t-3]);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] av [8];
        logic [15:0] bv [8];
        logic        en [8];
        logic        cl [8];
        logic [31:0] ed [8];
        av = '{16'd2, 16'd4, 16'd6, 16'd1, 16'd10, 16'd3, 16'd5, 16'd2};
        bv = '{16'd3, 16'd5, 16'd7, 16'd1, 16'd10, 16'd3, 16'd5, 16'd1};
        en = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,   1'b1,  1'b0,  1'b1};
        cl = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,   1'b0,  1'b1,  1'b0};
        ed = '{32'd6, 32'd26, 32'd68, 32'd1, 32'd100, 32'd10, 32'd25, 32'd12};
        for (int t = 0; t < 11; t++) begin
            if (t < 8) drive(av[t], bv[t], 1'b1, en[t], cl[t]);
            else       drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (t >= 2 && t < 10) begin
                n_vec++;
                if (n3_valid !== 1'b1 || n3_dout !== ed[t-2]) begin
                    n_err++;
                    $display("FAIL acc_n3_%0d: got v=%b d=%0d, expected v=1 d=%0d", t - 2, n3_valid, n3_dout, ed[t-2]);
                end
            end
            if (t >= 3) begin
                n_vec++;
                if (def_valid !== 1'b1 || def_dout !== ed[t-3] || def_sat !== 1'b0) begin
                    n_err++;
                    $display("FAIL acc_def_%0d: got v=%b d=%0d s=%b, expected v=1 d=%0d s=0",
                             t - 3, def_valid, def_dout, def_sat, ed[t-3]);
                end
            end
        end
        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++;
        if (def_valid !== 1'b0 || def_dout !== 32'd12) begin
            n_err++;
            $display("FAIL acc_bubble: got v=%b d=%0d, expected v=0 d=12", def_valid, def_dout);
        end
    endtask

    task automatic test_shift_sat();
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic [31:0] es [6];
        logic [7:0]  eu [6];
        logic        eus [6];
        av  = '{16'd3, 16'd5, 16'd300, 16'd255, 16'd1, 16'd1};
        bv  = '{16'd2, 16'd1, 16'd1,   16'd1,   16'd2, 16'd1};
        es  = '{32'd2, 32'd1, 32'd75,  32'd64,  32'd1, 32'd0};
        eu  = '{8'd6,  8'd5,  8'd255,  8'd255,  8'd2,  8'd1};
        eus = '{1'b0,  1'b0,  1'b1,    1'b0,    1'b0,  1'b0};
        for (int t = 0; t < 9; t++) begin
            if (t < 6) drive(av[t], bv[t], 1'b1, 1'b0, 1'b0);
            else       drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (t >= 3) begin
                n_vec++;
                if (shf_valid !== 1'b1 || shf_dout !== es[t-3]) begin
                    n_err++;
                    $display("FAIL shift_%0d: got v=%b d=%0d, expected v=1 d=%0d", t - 3, shf_valid, shf_dout, es[t-3]);
                end
                n_vec++;
                if (u8_valid !== 1'b1 || u8_dout !== eu[t-3] || u8_sat !== eus[t-3]) begin
                    n_err++;
                    $display("FAIL usat_%0d: got v=%b d=%0d s=%b, expected v=1 d=%0d s=%b",
                             t - 3, u8_valid, u8_dout, u8_sat, eu[t-3], eus[t-3]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic        ev [4];
        logic [31:0] ed [4];
        ev = '{1'b1, 1'b1, 1'b0, 1'b1};
        ed = '{32'd26, 32'd68, 32'd68, 32'd70};
        drive(16'd2, 16'd3, 1'b1, 1'b1, 1'b1); step();
        drive(16'd4, 16'd5, 1'b1, 1'b1, 1'b0); step();
        drive(16'd6, 16'd7, 1'b1, 1'b1, 1'b0); step();
        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0); step();
        n_vec++;
        if (def_valid !== 1'b1 || def_dout !== 32'd6) begin
            n_err++;
            $display("FAIL stall_pre: got v=%b d=%0d, expected v=1 d=6", def_valid, def_dout);
        end
        drive(16'd1, 16'd2, 1'b1, 1'b1, 1'b0);
        ce = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            n_vec++;
            if (def_valid !== 1'b1 || def_dout !== 32'd6 || def_sat !== 1'b0 ||
                n3_valid !== 1'b1 || n3_dout !== 32'd26) begin
                n_err++;
                $display("FAIL stall_frozen_%0d: got v=%b d=%0d s=%b n3v=%b n3d=%0d, expected v=1 d=6 s=0 n3v=1 n3d=26",
                         t, def_valid, def_dout, def_sat, n3_valid, n3_dout);
            end
        end
        ce = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (def_valid !== ev[t] || def_dout !== ed[t]) begin
                n_err++;
                $display("FAIL stall_resume_%0d: got v=%b d=%0d, expected v=%b d=%0d",
                         t, def_valid, def_dout, ev[t], ed[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(16'd2, 16'd3, 1'b1, 1'b1, 1'b1); step();
        drive(16'd4, 16'd5, 1'b1, 1'b1, 1'b0); step();
        drive(16'd6, 16'd7, 1'b1, 1'b1, 1'b0); step();
        drive(16'd8, 16'd9, 1'b1, 1'b1, 1'b0); step();
        drive(16'd1, 16'd1, 1'b1, 1'b1, 1'b0); step();
        n_vec++;
        if (def_valid !== 1'b1 || def_dout !== 32'd26) begin
            n_err++;
            $display("FAIL rstmid_pre: got v=%b d=%0d, expected v=1 d=26", def_valid, def_dout);
        end
        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        ce    = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ce    = 1'b1;
        n_vec++;
        if (def_valid !== 1'b0 || def_dout !== 32'd0 || def_sat !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_now: got v=%b d=%0d s=%b, expected v=0 d=0 s=0", def_valid, def_dout, def_sat);
        end
        for (int t = 0; t < 6; t++) begin
            step();
            n_vec++;
            if (def_valid !== 1'b0 || def_dout !== 32'd0) begin
                n_err++;
                $display("FAIL rstmid_quiet_%0d: got v=%b d=%0d, expected v=0 d=0", t, def_valid, def_dout);
            end
        end
        for (int t = 0; t < 4; t++) begin
            if (t == 0) drive(16'd2, 16'd2, 1'b1, 1'b1, 1'b0);
            else        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            step();
        end
        n_vec++;
        if (def_valid !== 1'b1 || def_dout !== 32'd4) begin
            n_err++;
            $display("FAIL rstmid_new: got v=%b d=%0d, expected v=1 d=4", def_valid, def_dout);
        end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_latency();
        test_signed();
        test_accumulate();
        test_shift_sat();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fast_accel_mac_pipe.md
Name: fast_accel_mac_pipe

Overview:
Parametrised, fully pipelined multiply / multiply-accumulate datapath for the fast_accel kernels. It generalises the fixed 16x16 unsigned 4-stage multiplier:
- configurable operand widths, signedness and pipeline depth;
- valid tracking;
- optional accumulation with clear;
- round-half-up right shift;
- saturating output.

It sits between the pixel-gradient stages and the score/threshold logic. It is instantiated once per channel.

Parameters:
A_WIDTH, 16, din0 width
B_WIDTH, 16, din1 width
A_SIGNED, 0, 1 = din0 is two's complement
B_SIGNED, 0, 1 = din1 is two's complement
NUM_STAGE, 4, total latency in ce-enabled cycles; legal range 3..8
ACC_WIDTH, 48, accumulator width; must be >= A_WIDTH+B_WIDTH
SHIFT, 0, right shift applied to the accumulator before output; 0..ACC_WIDTH-1
OUT_WIDTH, 32, dout width

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; low freezes every pipeline register
in_valid  in  1  din0/din1/acc_* qualify this cycle
din0  in  A_WIDTH  multiplicand
din1  in  B_WIDTH  multiplier
acc_en  in  1  1 = add product to accumulator; 0 = plain multiply
acc_clr  in  1  with acc_en: accumulator restarts from this product
out_valid  out  1  dout/sat valid
dout  out  OUT_WIDTH  rounded, saturated result
sat  out  1  dout was clipped this result

Behaviour:
- Reset (reset=1 at a clk edge, regardless of ce):
  - out_valid, dout, sat and the accumulator go to 0.
  - All internal valid bits are cleared; in-flight data is discarded.
  - Reset mid-operation produces no out_valid until new inputs have travelled the full pipeline.
- ce=0: no register changes, including valid bits and the accumulator. Outputs hold their values.
- Signedness: RES_SIGNED = A_SIGNED | B_SIGNED.
  - Unsigned operands are zero-extended by 1 bit before multiplying.
  - Product width is A_WIDTH+B_WIDTH and is exact.
- Pipeline, with ce=1:
  - Stage 1 registers din0, din1, in_valid, acc_en, acc_clr.
  - Stage 2 registers the product plus the sideband bits.
  - Stages 3..NUM_STAGE-1 are pure delay registers (product + sideband).
  - Stage NUM_STAGE is the accumulate / output register.
- Latency: inputs presented at ce-enabled edge k appear on dout/out_valid after edge k+NUM_STAGE-1. With continuous ce, that is NUM_STAGE cycles after presentation. Throughput is 1 per cycle.
- Final stage, only when the sideband valid bit is 1:
  - Form P = product sign-/zero-extended to ACC_WIDTH.
  - acc_en=0: next = P; the accumulator is unchanged.
  - acc_en=1, acc_clr=1: next = P; acc <= P.
  - acc_en=1, acc_clr=0: next = acc + P, wrapping modulo 2^ACC_WIDTH; acc <= next.
  - Arithmetic shift if RES_SIGNED, else logical. If SHIFT>0: R = (next + 2^(SHIFT-1)) >> SHIFT, computed in ACC_WIDTH+1 bits. If SHIFT=0: R = next.
  - Saturate R to OUT_WIDTH: signed range if RES_SIGNED, else 0..2^OUT_WIDTH-1. sat=1 iff clipping occurred.
  - If OUT_WIDTH >= the width of R, extend R instead; sat is always 0.
  - Registers: dout <= saturated R; out_valid <= 1.
- Final-stage bubble (valid bit 0): out_valid <= 0; dout, sat and the accumulator hold their values.
- acc_clr with acc_en=0 is ignored.

Decomposition:
- Package fast_accel_mac_pkg holds:
  - constants NUM_STAGE_MIN=3 and NUM_STAGE_MAX=8;
  - a sideband struct {valid, acc_en, acc_clr};
  - functions sat_signed and sat_unsigned (width-generic via parameters at the call site).
- Sub-module fast_accel_mac_dly: a parametrised ce-gated delay line (DEPTH, WIDTH, synchronous reset), used for stages 3..NUM_STAGE-1. DEPTH=0 is a pass-through.
- Parameter legality is checked by elaboration-time assertions.

Test Plan:
1. Defaults, in_valid=1, acc_en=0, din0=din1=65535, ce=1 -> dout=0xFFFE0001 and out_valid=1 exactly 4 cycles later; sat=0.
2. A_SIGNED=B_SIGNED=1, OUT_WIDTH=16, din0=-3, din1=5 -> dout=0xFFF1 (-15), sat=0. Also din0=-32768, din1=-32768 -> dout=32767, sat=1.
3. acc_en=1 stream (2,3) with clr, (4,5), (6,7) on consecutive cycles -> dout=6, 26, 68 on consecutive out_valid cycles. Then (1,1) with clr -> dout=1.
4. SHIFT=2 with acc_en=0 and inputs (3,2) then (5,1) -> dout=2 then 1 (round half-up on 6/4 and 5/4). Unsigned OUT_WIDTH=8 with 300*1 -> dout=255, sat=1.
5. ce low for 3 cycles mid-stream -> all outputs frozen, and the result sequence is identical to an unstalled run, only delayed by 3 cycles.
6. reset pulsed with 3 items in flight and accumulator=26 -> out_valid stays 0 and dout=0 until a new item arrives. A new acc_en=1, acc_clr=0 item (2,2) yields dout=4.
